// File: rtl/rect_fill_pkg.sv
// Shared encodings and bus-geometry helpers for the rectangle fill generator.
package rect_fill_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_DRIVE,
    ST_DONE
  } state_t;

  localparam logic MODE_FILL    = 1'b0;
  localparam logic MODE_OUTLINE = 1'b1;
  localparam logic OP_IDLE      = 1'b0;
  localparam logic OP_WRITE     = 1'b1;

  function automatic int lanes_of(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int lane_w_of(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/rect_fill_lane_mask.sv
// Byte-lane enable mask for one word group of the current rectangle row.
module rect_fill_lane_mask
  import rect_fill_pkg::*;
#(
  parameter int DIM_W  = 16,
  parameter int DATA_W = 32,
  localparam int LANES = lanes_of(DATA_W),
  localparam int LW    = lane_w_of(DATA_W)
) (
  input  logic [DIM_W-LW:0] grp,
  input  logic [LW-1:0]     x_lane,
  input  logic [DIM_W:0]    end_lane,
  input  logic              interior,
  output logic [LANES-1:0]  mask,
  output logic              zero
);

  logic [DIM_W:0] x_ext;
  assign x_ext = (DIM_W+1)'(x_lane);

  // Absolute lane position is the group index with the lane number appended.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    localparam logic [LW-1:0] LI = LW'(gi);
    logic [DIM_W:0] pos;
    assign pos = {grp, LI};
    assign mask[gi] = (pos >= x_ext) && (pos <= end_lane) &&
                      (!interior || pos == x_ext || pos == end_lane);
  end

  assign zero = ~|mask;

endmodule

// File: rtl/rect_fill_gen_engine.sv
// Walks a byte-lane rectangle row by row, issuing one masked write per colour
// channel per word group to the memory arbiter.
module rect_fill_gen_engine
  import rect_fill_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DIM_W      = 16,
  parameter int DATA_W     = 32,
  parameter int COLOR_W    = 4,
  parameter int NUM_CH     = 3,
  parameter int ROW_STRIDE = 240
) (
  input  logic                         clk,
  input  logic                         rst_,
  input  logic                         gen_start_strobe,
  input  logic [ADDR_W-1:0]            init_addr,
  input  logic [DIM_W-1:0]             cmd_data_hgt,
  input  logic [DIM_W-1:0]             cmd_data_wid,
  input  logic [lane_w_of(DATA_W)-1:0] cmd_x_lane,
  input  logic                         cmd_mode,
  input  logic [NUM_CH*COLOR_W-1:0]    cmd_color,
  output logic                         data_gen_is_idle,
  output logic                         gen_done,
  output logic                         arb_out_rts,
  input  logic                         arb_in_rtr,
  output logic [lanes_of(DATA_W)-1:0]  arb_out_wben,
  output logic [ADDR_W-1:0]            arb_out_addr,
  output logic [DATA_W-1:0]            arb_out_data,
  output logic                         arb_out_op
);

  localparam int LANES = lanes_of(DATA_W);
  localparam int LW    = lane_w_of(DATA_W);
  localparam int GW    = DIM_W + 1 - LW;
  localparam int CHW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int REP   = DATA_W / COLOR_W;

  state_t                    state_reg;
  logic [DIM_W-1:0]          hgt_reg, wid_reg, row_reg;
  logic [LW-1:0]             x_lane_reg;
  logic                      mode_reg;
  logic [NUM_CH*COLOR_W-1:0] color_reg;
  logic [GW-1:0]             grp_reg;
  logic [CHW-1:0]            ch_reg;
  logic [ADDR_W-1:0]         row_base_reg;

  logic [DIM_W:0]     end_lane;
  logic [GW-1:0]      last_grp;
  logic               xfc, cur_interior, next_interior, final_xfc, next_zero;
  logic [DIM_W-1:0]   row_next;
  logic [GW-1:0]      grp_next;
  logic [CHW-1:0]     ch_next;
  logic [ADDR_W-1:0]  row_base_next, addr_next;
  logic [DATA_W-1:0]  data_next;
  logic [LANES-1:0]   mask_next;

  assign end_lane = (DIM_W+1)'(wid_reg) + (DIM_W+1)'(x_lane_reg) - (DIM_W+1)'(1);
  assign last_grp = end_lane[DIM_W:LW];
  assign xfc      = arb_out_rts & arb_in_rtr;
  assign cur_interior = (mode_reg == MODE_OUTLINE) && (row_reg != '0) &&
                        (row_reg != hgt_reg - 1'b1);

  // Next beat position; in SETUP the cleared counters describe the first beat.
  always_comb begin
    row_next      = row_reg;
    grp_next      = grp_reg;
    ch_next       = ch_reg;
    row_base_next = row_base_reg;
    final_xfc     = 1'b0;
    if (state_reg == ST_DRIVE) begin
      if (ch_reg != CHW'(NUM_CH - 1)) begin
        ch_next = ch_reg + 1'b1;
      end else begin
        ch_next = '0;
        if (grp_reg != last_grp) begin
          // Interior outline rows only touch the first and last groups.
          grp_next = (cur_interior && grp_reg == '0) ? last_grp : grp_reg + 1'b1;
        end else if (row_reg != hgt_reg - 1'b1) begin
          grp_next      = '0;
          row_next      = row_reg + 1'b1;
          row_base_next = row_base_reg + ADDR_W'(ROW_STRIDE);
        end else begin
          final_xfc = 1'b1;
        end
      end
    end
  end

  assign next_interior = (mode_reg == MODE_OUTLINE) && (row_next != '0) &&
                         (row_next != hgt_reg - 1'b1);
  assign addr_next = row_base_next + ADDR_W'(grp_next * NUM_CH) + ADDR_W'(ch_next);
  assign data_next = {REP{color_reg[ch_next*COLOR_W +: COLOR_W]}};

  rect_fill_lane_mask #(
    .DIM_W  (DIM_W),
    .DATA_W (DATA_W)
  ) u_lane_mask (
    .grp      (grp_next),
    .x_lane   (x_lane_reg),
    .end_lane (end_lane),
    .interior (next_interior),
    .mask     (mask_next),
    .zero     (next_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_reg        <= ST_IDLE;
      hgt_reg          <= '0;
      wid_reg          <= '0;
      row_reg          <= '0;
      x_lane_reg       <= '0;
      mode_reg         <= MODE_FILL;
      color_reg        <= '0;
      grp_reg          <= '0;
      ch_reg           <= '0;
      row_base_reg     <= '0;
      data_gen_is_idle <= 1'b1;
      gen_done         <= 1'b0;
      arb_out_rts      <= 1'b0;
      arb_out_wben     <= '0;
      arb_out_addr     <= '0;
      arb_out_data     <= '0;
      arb_out_op       <= OP_IDLE;
    end else begin
      gen_done <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (gen_start_strobe) begin
            hgt_reg          <= cmd_data_hgt;
            wid_reg          <= cmd_data_wid;
            x_lane_reg       <= cmd_x_lane;
            mode_reg         <= cmd_mode;
            color_reg        <= cmd_color;
            row_base_reg     <= init_addr;
            row_reg          <= '0;
            grp_reg          <= '0;
            ch_reg           <= '0;
            data_gen_is_idle <= 1'b0;
            state_reg        <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (hgt_reg == '0 || wid_reg == '0 || next_zero) begin
            gen_done  <= 1'b1;
            state_reg <= ST_DONE;
          end else begin
            arb_out_rts  <= 1'b1;
            arb_out_op   <= OP_WRITE;
            arb_out_wben <= mask_next;
            arb_out_addr <= addr_next;
            arb_out_data <= data_next;
            state_reg    <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (xfc) begin
            if (final_xfc) begin
              arb_out_rts  <= 1'b0;
              arb_out_op   <= OP_IDLE;
              arb_out_wben <= '0;
              gen_done     <= 1'b1;
              state_reg    <= ST_DONE;
            end else begin
              row_reg      <= row_next;
              grp_reg      <= grp_next;
              ch_reg       <= ch_next;
              row_base_reg <= row_base_next;
              arb_out_wben <= mask_next;
              arb_out_addr <= addr_next;
              arb_out_data <= data_next;
            end
          end
        end
        ST_DONE: begin
          data_gen_is_idle <= 1'b1;
          state_reg        <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rect_fill_gen_engine.sv
// Scoreboard bench: directed commands push expected writes, a negedge monitor checks them.
module tb_rect_fill_gen_engine;

  logic        clk = 1'b0;
  logic        rst_ = 1'b0;
  logic        start = 1'b0;
  logic [15:0] init_addr = '0, hgt = '0, wid = '0;
  logic [1:0]  x_lane = '0;
  logic        mode = 1'b0;
  logic [11:0] color = '0;
  logic        idle, done, rts, rtr, op;
  logic [3:0]  wben;
  logic [15:0] addr;
  logic [31:0] data;

  always #5 clk = ~clk;

  rect_fill_gen_engine dut (
    .clk              (clk),
    .rst_             (rst_),
    .gen_start_strobe (start),
    .init_addr        (init_addr),
    .cmd_data_hgt     (hgt),
    .cmd_data_wid     (wid),
    .cmd_x_lane       (x_lane),
    .cmd_mode         (mode),
    .cmd_color        (color),
    .data_gen_is_idle (idle),
    .gen_done         (done),
    .arb_out_rts      (rts),
    .arb_in_rtr       (rtr),
    .arb_out_wben     (wben),
    .arb_out_addr     (addr),
    .arb_out_data     (data),
    .arb_out_op       (op)
  );

  typedef struct packed {
    logic [15:0] addr;
    logic [3:0]  wben;
    logic [31:0] data;
  } wr_t;

  wr_t sb[$];
  int  n_pass = 0;
  int  n_total = 0;
  int  xfc_cnt = 0;
  int  done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push(input logic [15:0] a, input logic [3:0] m, input logic [31:0] d);
    sb.push_back('{addr: a, wben: m, data: d});
  endtask

  // One row of the x_lane=2, wid=3 fill: lanes 2-3 of group 0, lane 0 of group 1.
  task automatic push_fill_row(input logic [15:0] base);
    push(base + 16'd0, 4'b1100, 32'hAAAAAAAA);
    push(base + 16'd1, 4'b1100, 32'h55555555);
    push(base + 16'd2, 4'b1100, 32'hCCCCCCCC);
    push(base + 16'd3, 4'b0001, 32'hAAAAAAAA);
    push(base + 16'd4, 4'b0001, 32'h55555555);
    push(base + 16'd5, 4'b0001, 32'hCCCCCCCC);
  endtask

  task automatic start_cmd(input logic [15:0] ia, input logic [15:0] h, input logic [15:0] w,
                           input logic [1:0] xl, input logic md, input logic [11:0] col);
    @(posedge clk); #1;
    init_addr = ia; hgt = h; wid = w; x_lane = xl; mode = md; color = col;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Waits for the scoreboard to drain, then expects a single done pulse next cycle.
  task automatic wait_done(input string name);
    int k = 0;
    while (sb.size() != 0 && k < 400) begin
      @(negedge clk); #1;
      k++;
    end
    check({name, "_drain"}, sb.size(), 0);
    @(negedge clk); #1;
    check({name, "_done_pulse"}, {30'd0, done, rts}, 32'd2);
    @(negedge clk); #1;
    check({name, "_done_clear"}, {30'd0, done, idle}, 32'd1);
  endtask

  // Monitor: pops on every transfer and checks stability of stalled requests.
  initial begin
    wr_t e;
    wr_t held;
    bit  hold_v;
    hold_v = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_) begin
        hold_v = 1'b0;
      end else begin
        if (done) done_cnt++;
        if (rts) check("op_with_rts", {31'd0, op}, 32'd1);
        if (hold_v) begin
          check("hold_addr", {16'd0, addr}, {16'd0, held.addr});
          check("hold_wben", {28'd0, wben}, {28'd0, held.wben});
          check("hold_data", data, held.data);
        end
        if (rts && rtr) begin
          if (sb.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_write: got addr %h wben %b data %h expected no write", addr, wben, data);
          end else begin
            e = sb.pop_front();
            $display("write addr %h wben %b data %h", addr, wben, data);
            check("wr_addr", {16'd0, addr}, {16'd0, e.addr});
            check("wr_wben", {28'd0, wben}, {28'd0, e.wben});
            check("wr_data", data, e.data);
          end
          xfc_cnt++;
        end
        hold_v = rts && !rtr;
        held = '{addr: addr, wben: wben, data: data};
      end
    end
  end

  initial begin
    int base;
    int dbase;
    int k;
    rtr = 1'b1;

    // Reset state while rst_ is held low.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rts", {31'd0, rts}, 32'd0);
    check("rst_idle", {31'd0, idle}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_op", {31'd0, op}, 32'd0);
    check("rst_wben", {28'd0, wben}, 32'd0);
    check("rst_addr", {16'd0, addr}, 32'd0);
    check("rst_data", data, 32'd0);
    @(posedge clk); #1;
    rst_ = 1'b1;

    // Fill, two rows, no stalls; first request two edges after the strobe.
    push_fill_row(16'h0100);
    push_fill_row(16'h01F0);
    base = xfc_cnt;
    start_cmd(16'h0100, 16'd2, 16'd3, 2'd2, 1'b0, 12'hC5A);
    @(negedge clk); #1;
    check("setup_no_rts", {31'd0, rts}, 32'd0);
    check("busy_not_idle", {31'd0, idle}, 32'd0);
    @(negedge clk); #1;
    check("first_req_latency", xfc_cnt - base, 32'd1);
    wait_done("fill");
    check("fill_count", xfc_cnt - base, 32'd12);
    $display("fill done writes %0d", xfc_cnt - base);

    // Same command, arbiter stalls the fourth write for three cycles.
    push_fill_row(16'h0100);
    push_fill_row(16'h01F0);
    base = xfc_cnt;
    start_cmd(16'h0100, 16'd2, 16'd3, 2'd2, 1'b0, 12'hC5A);
    k = 0;
    while (!(xfc_cnt == base + 3 && rts) && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("stall_reach", xfc_cnt - base, 32'd3);
    rtr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("stall_addr", {16'd0, addr}, 32'h0103);
    check("stall_wben", {28'd0, wben}, 32'h1);
    rtr = 1'b1;
    wait_done("stall");
    check("stall_count", xfc_cnt - base, 32'd12);
    $display("stall done writes %0d", xfc_cnt - base);

    // Outline, three rows of twelve lanes; middle row skips group 1.
    for (int r = 0; r < 3; r++) begin
      for (int a = 0; a < 9; a++) begin
        logic [15:0] ad;
        logic [31:0] dv;
        ad = 16'(r * 240 + a);
        dv = (a % 3 == 0) ? 32'h11111111 : (a % 3 == 1) ? 32'h22222222 : 32'h33333333;
        if (r != 1) push(ad, 4'b1111, dv);
        else if (a < 3) push(ad, 4'b0001, dv);
        else if (a >= 6) push(ad, 4'b1000, dv);
      end
    end
    base = xfc_cnt;
    start_cmd(16'h0000, 16'd3, 16'd12, 2'd0, 1'b1, 12'h321);
    wait_done("outline");
    check("outline_count", xfc_cnt - base, 32'd24);
    $display("outline done writes %0d", xfc_cnt - base);

    // Empty rectangles: wid=0 then hgt=0 finish without any request.
    for (int t = 0; t < 2; t++) begin
      base = xfc_cnt;
      dbase = done_cnt;
      if (t == 0) start_cmd(16'h0040, 16'd5, 16'd0, 2'd1, 1'b0, 12'h123);
      else        start_cmd(16'h0040, 16'd0, 16'd3, 2'd1, 1'b0, 12'h123);
      @(negedge clk); #1;
      check("empty_setup", {30'd0, done, rts}, 32'd0);
      @(negedge clk); #1;
      check("empty_done", {29'd0, done, rts, idle}, 32'd4);
      @(negedge clk); #1;
      check("empty_idle", {29'd0, done, rts, idle}, 32'd1);
      check("empty_no_write", xfc_cnt - base, 32'd0);
      check("empty_one_done", done_cnt - dbase, 32'd1);
      $display("empty case %0d done", t);
    end

    // Address wrap, with a second strobe during DRIVE that must be ignored.
    push(16'hFFFE, 4'b1111, 32'hFFFFFFFF);
    push(16'hFFFF, 4'b1111, 32'h00000000);
    push(16'h0000, 4'b1111, 32'h66666666);
    base = xfc_cnt;
    rtr = 1'b0;
    start_cmd(16'hFFFE, 16'd1, 16'd4, 2'd0, 1'b0, 12'h60F);
    repeat (3) @(posedge clk);
    #1;
    init_addr = 16'h1234; wid = 16'd8; hgt = 16'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rtr = 1'b1;
    wait_done("wrap");
    repeat (6) @(negedge clk);
    #1;
    check("wrap_count", xfc_cnt - base, 32'd3);
    check("wrap_idle", {31'd0, idle}, 32'd1);
    $display("wrap done writes %0d", xfc_cnt - base);

    // Reset mid-DRIVE aborts; a fresh start then runs the whole rectangle.
    push_fill_row(16'h0100);
    push_fill_row(16'h01F0);
    base = xfc_cnt;
    dbase = done_cnt;
    start_cmd(16'h0100, 16'd2, 16'd3, 2'd2, 1'b0, 12'hC5A);
    k = 0;
    while (xfc_cnt < base + 5 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    rst_ = 1'b0;
    @(posedge clk); #1;
    rst_ = 1'b1;
    check("abort_state", {29'd0, rts, idle, done}, 32'd2);
    check("abort_partial", xfc_cnt - base, 32'd5);
    sb.delete();
    repeat (3) @(negedge clk);
    #1;
    check("abort_no_done", done_cnt - dbase, 32'd0);
    push_fill_row(16'h0100);
    push_fill_row(16'h01F0);
    base = xfc_cnt;
    start_cmd(16'h0100, 16'd2, 16'd3, 2'd2, 1'b0, 12'hC5A);
    wait_done("rerun");
    check("rerun_count", xfc_cnt - base, 32'd12);
    $display("rerun done writes %0d", xfc_cnt - base);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
